edge_stream_packer: RTL and testbench



---
 rtl/edge_stream_packer.sv | 123 ++++++++++++
 tb/tb_edge_stream_packer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_stream_packer.sv
// edge_stream_packer
// Packs the 8-bit edge-pixel stream into 32-bit words (first pixel in [7:0])
// and adds end-of-frame framing (TLAST/TKEEP) for the S2MM DMA channel.
// The final word of a frame may be partial and never merges with the next frame.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_data_valid, i_data      pixel stream in
//   o_data_ready              pixel accept (combinational from i_data_ready)
//   o_data_valid, o_data      packed word out
//   o_data_keep, o_data_last  TKEEP / TLAST of the packed word
//   i_data_ready              downstream ready
//   o_frame_done              one-cycle pulse after the last word of a frame is taken
//   o_frame_count             completed frames, wraps to 0
module edge_stream_packer #(
    parameter int unsigned FRAME_PIXELS = 262144,
    parameter int unsigned FCNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_data_valid,
    input  logic [7:0]        i_data,
    output logic              o_data_ready,
    output logic              o_data_valid,
    output logic [31:0]       o_data,
    output logic [3:0]        o_data_keep,
    output logic              o_data_last,
    input  logic              i_data_ready,
    output logic              o_frame_done,
    output logic [FCNT_W-1:0] o_frame_count
);

    localparam int unsigned       PCNT_W   = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [PCNT_W-1:0] LAST_PIX = PCNT_W'(FRAME_PIXELS - 1);

    logic [23:0]       asm_q;
    logic [1:0]        idx_q;
    logic [PCNT_W-1:0] pix_cnt_q;

    logic        accept;
    logic        xfer;
    logic        frame_last;
    logic        complete;
    logic [31:0] word_c;
    logic [3:0]  keep_c;

    // Accept a pixel whenever the output slot is empty or being drained this cycle.
    assign o_data_ready = !i_rst && (!o_data_valid || i_data_ready);
    assign accept       = i_data_valid && o_data_ready;
    assign xfer         = o_data_valid && i_data_ready;
    assign frame_last   = (pix_cnt_q == LAST_PIX);
    assign complete     = accept && ((idx_q == 2'd3) || frame_last);

    // Completed word: assembled bytes below the index, current pixel at the index,
    // zeros above (stale assembly bytes from an earlier word are masked off).
    always_comb begin
        word_c = 32'd0;
        keep_c = 4'd0;
        unique case (idx_q)
            2'd0: begin
                word_c = {24'd0, i_data};
                keep_c = 4'b0001;
            end
            2'd1: begin
                word_c = {16'd0, i_data, asm_q[7:0]};
                keep_c = 4'b0011;
            end
            2'd2: begin
                word_c = {8'd0, i_data, asm_q[15:0]};
                keep_c = 4'b0111;
            end
            default: begin
                word_c = {i_data, asm_q};
                keep_c = 4'b1111;
            end
        endcase
    end

    // Assembly, pixel counting, output register and frame accounting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            asm_q         <= 24'd0;
            idx_q         <= 2'd0;
            pix_cnt_q     <= '0;
            o_data_valid  <= 1'b0;
            o_data        <= 32'd0;
            o_data_keep   <= 4'd0;
            o_data_last   <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_count <= '0;
        end else begin
            o_frame_done <= xfer && o_data_last;
            if (xfer && o_data_last) begin
                o_frame_count <= o_frame_count + FCNT_W'(1);
            end

            if (accept) begin
                pix_cnt_q <= frame_last ? '0 : pix_cnt_q + PCNT_W'(1);
                if (complete) begin
                    idx_q <= 2'd0;
                end else begin
                    idx_q <= idx_q + 2'd1;
                    unique case (idx_q)
                        2'd0:    asm_q[7:0]   <= i_data;
                        2'd1:    asm_q[15:8]  <= i_data;
                        default: asm_q[23:16] <= i_data;
                    endcase
                end
            end

            // A completion in the same cycle as a transfer simply replaces the word.
            if (complete) begin
                o_data_valid <= 1'b1;
                o_data       <= word_c;
                o_data_keep  <= keep_c;
                o_data_last  <= frame_last;
            end else if (xfer) begin
                o_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_stream_packer.sv
// Bench for edge_stream_packer: three instances (8, 10 and 1 pixels per frame),
// a queue-based reference model checked every cycle, and literal expectations.
module tb_edge_stream_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk;
    logic        rst;
    logic        vld   [3];
    logic [7:0]  dat   [3];
    logic        rdy   [3];
    logic        ordy  [3];
    logic        ovld  [3];
    logic [31:0] odat  [3];
    logic [3:0]  okeep [3];
    logic        olast [3];
    logic        odone [3];
    logic [15:0] ofcnt [3];

    int fp [3] = '{8, 10, 1};

    int errors = 0;
    int checks = 0;

    // Reference model state
    word_t       exp_q [3][$];
    word_t       log_q [3][$];
    logic [31:0] asm_w [3];
    int          asm_n [3];
    int          pix_n [3];
    logic        exp_done [3];
    logic [15:0] exp_fcnt [3];
    int          done_cnt [3];
    int          stalls   [3];

    edge_stream_packer #(.FRAME_PIXELS(8), .FCNT_W(16)) u_fp8 (
        .i_clk(clk), .i_rst(rst), .i_data_valid(vld[0]), .i_data(dat[0]),
        .o_data_ready(ordy[0]), .o_data_valid(ovld[0]), .o_data(odat[0]),
        .o_data_keep(okeep[0]), .o_data_last(olast[0]), .i_data_ready(rdy[0]),
        .o_frame_done(odone[0]), .o_frame_count(ofcnt[0]));

    edge_stream_packer #(.FRAME_PIXELS(10), .FCNT_W(16)) u_fp10 (
        .i_clk(clk), .i_rst(rst), .i_data_valid(vld[1]), .i_data(dat[1]),
        .o_data_ready(ordy[1]), .o_data_valid(ovld[1]), .o_data(odat[1]),
        .o_data_keep(okeep[1]), .o_data_last(olast[1]), .i_data_ready(rdy[1]),
        .o_frame_done(odone[1]), .o_frame_count(ofcnt[1]));

    edge_stream_packer #(.FRAME_PIXELS(1), .FCNT_W(16)) u_fp1 (
        .i_clk(clk), .i_rst(rst), .i_data_valid(vld[2]), .i_data(dat[2]),
        .o_data_ready(ordy[2]), .o_data_valid(ovld[2]), .o_data(odat[2]),
        .o_data_keep(okeep[2]), .o_data_last(olast[2]), .i_data_ready(rdy[2]),
        .o_frame_done(odone[2]), .o_frame_count(ofcnt[2]));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_word(input string name, input int d, input int i,
                            input logic [31:0] data, input logic [3:0] keep, input logic last);
        word_t w;
        if (i < log_q[d].size()) begin
            w = log_q[d][i];
            chk(name, {27'd0, w}, {27'd0, data, keep, last});
        end else begin
            chk({name, "_missing"}, 64'(log_q[d].size()), 64'(i + 1));
        end
    endtask

    // Per-cycle compare, then advance the model by the handshakes of the coming edge.
    task automatic model_step(input int d);
        logic  exp_v;
        logic  xfer;
        logic  acc;
        word_t w;
        exp_v = (exp_q[d].size() > 0);
        chk($sformatf("valid%0d", d), 64'(ovld[d]), 64'(exp_v));
        chk($sformatf("ready%0d", d), 64'(ordy[d]), 64'(!rst && (!exp_v || rdy[d])));
        chk($sformatf("done%0d", d), 64'(odone[d]), 64'(exp_done[d]));
        chk($sformatf("fcnt%0d", d), 64'(ofcnt[d]), 64'(exp_fcnt[d]));
        if (exp_v && ovld[d]) begin
            w = exp_q[d][0];
            chk($sformatf("data%0d", d), 64'(odat[d]), 64'(w.data));
            chk($sformatf("keep%0d", d), 64'(okeep[d]), 64'(w.keep));
            chk($sformatf("last%0d", d), 64'(olast[d]), 64'(w.last));
        end
        if (odone[d]) done_cnt[d]++;

        if (rst) begin
            exp_q[d].delete();
            asm_w[d]    = 32'd0;
            asm_n[d]    = 0;
            pix_n[d]    = 0;
            exp_done[d] = 1'b0;
            exp_fcnt[d] = 16'd0;
        end else begin
            xfer = ovld[d] && rdy[d] && exp_v;
            acc  = vld[d] && ordy[d];
            exp_done[d] = 1'b0;
            if (xfer) begin
                w = exp_q[d].pop_front();
                log_q[d].push_back({odat[d], okeep[d], olast[d]});
                if (w.last) begin
                    exp_done[d] = 1'b1;
                    exp_fcnt[d] = exp_fcnt[d] + 16'd1;
                end
            end
            if (acc) begin
                asm_w[d][8*asm_n[d] +: 8] = dat[d];
                asm_n[d]++;
                pix_n[d]++;
                if (asm_n[d] == 4 || pix_n[d] == fp[d]) begin
                    exp_q[d].push_back({asm_w[d], 4'((1 << asm_n[d]) - 1), pix_n[d] == fp[d]});
                    asm_w[d] = 32'd0;
                    asm_n[d] = 0;
                    if (pix_n[d] == fp[d]) pix_n[d] = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) model_step(d);
    end

    // Present one pixel and hold it until accepted (bounded).
    task automatic send_px(input int d, input logic [7:0] px);
        logic acc;
        int   n;
        vld[d] = 1'b1;
        dat[d] = px;
        acc    = 1'b0;
        n      = 0;
        while (!acc) begin
            @(negedge clk);
            acc = ordy[d];
            if (!acc) stalls[d]++;
            @(posedge clk);
            #1;
            if (!acc) begin
                n++;
                if (n > 200) begin
                    chk($sformatf("accept_timeout%0d", d), 64'd0, 64'd1);
                    acc = 1'b1;
                end
            end
        end
        vld[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 3; d++) begin
            log_q[d].delete();
            stalls[d]   = 0;
            done_cnt[d] = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rnd_done;
        int   n;
        clk = 1'b0;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            vld[d] = 1'b0; dat[d] = 8'd0; rdy[d] = 1'b1;
            asm_w[d] = 32'd0; asm_n[d] = 0; pix_n[d] = 0;
            exp_done[d] = 1'b0; exp_fcnt[d] = 16'd0;
        end
        clear_stats();
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 64'(ovld[0]), 64'd0);
        chk("reset_fcnt", 64'(ofcnt[1]), 64'd0);
        chk("reset_ready_after", 64'(ordy[2]), 64'd1);
        @(posedge clk);
        #1;

        // Frame of 8, back-to-back, no backpressure
        clear_stats();
        for (int i = 1; i <= 8; i++) send_px(0, 8'(i));
        idle(4);
        chk("t1_no_stall", 64'(stalls[0]), 64'd0);
        chk_word("t1_w0", 0, 0, 32'h04030201, 4'hF, 1'b0);
        chk_word("t1_w1", 0, 1, 32'h08070605, 4'hF, 1'b1);
        chk("t1_done_pulses", 64'(done_cnt[0]), 64'd1);
        chk("t1_fcnt", 64'(ofcnt[0]), 64'd1);

        // Two frames of 10: partial last word, no merge into next frame
        clear_stats();
        for (int i = 0; i < 10; i++) send_px(1, 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) send_px(1, 8'(8'h20 + i));
        idle(4);
        chk_word("t2_w0", 1, 0, 32'h13121110, 4'hF, 1'b0);
        chk_word("t2_w2", 1, 2, 32'h00001918, 4'h3, 1'b1);
        chk_word("t2_w3", 1, 3, 32'h23222120, 4'hF, 1'b0);
        chk("t2_fcnt", 64'(ofcnt[1]), 64'd2);

        // One pixel per frame
        clear_stats();
        send_px(2, 8'h55);
        send_px(2, 8'h66);
        idle(4);
        chk_word("t6_w0", 2, 0, 32'h00000055, 4'h1, 1'b1);
        chk_word("t6_w1", 2, 1, 32'h00000066, 4'h1, 1'b1);
        chk("t6_done_pulses", 64'(done_cnt[2]), 64'd2);

        // Backpressure: downstream stalls 5 cycles once the first word is valid
        clear_stats();
        rdy[0] = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send_px(0, 8'(i));
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!ovld[0] && n < 100);
                if (n >= 100) chk("t3_valid_timeout", 64'd0, 64'd1);
                repeat (5) @(posedge clk);
                #1;
                rdy[0] = 1'b1;
            end
        join
        idle(4);
        chk("t3_stall_cycles", 64'(stalls[0]), 64'd5);
        chk_word("t3_w0", 0, 0, 32'h04030201, 4'hF, 1'b0);
        chk_word("t3_w1", 0, 1, 32'h08070605, 4'hF, 1'b1);
        chk("t3_words", 64'(log_q[0].size()), 64'd2);
        chk("t3_fcnt", 64'(ofcnt[0]), 64'd2);

        // Reset mid-word (fp10) and with a pending word (fp8)
        clear_stats();
        send_px(1, 8'hA1);
        send_px(1, 8'hA2);
        rdy[0] = 1'b0;
        for (int i = 1; i <= 4; i++) send_px(0, 8'(8'hA0 + i));
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ready_in_reset0", 64'(ordy[0]), 64'd0);
        chk("t5_ready_in_reset1", 64'(ordy[1]), 64'd0);
        @(negedge clk);
        chk("t5_rst_valid", 64'(ovld[0]), 64'd0);
        chk("t5_rst_data", 64'(odat[0]), 64'd0);
        chk("t5_rst_keep", 64'(okeep[0]), 64'd0);
        chk("t5_rst_last", 64'(olast[0]), 64'd0);
        chk("t5_rst_fcnt", 64'(ofcnt[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy[0] = 1'b1;
        clear_stats();
        for (int i = 1; i <= 8; i++) send_px(0, 8'(i));
        for (int i = 0; i < 4; i++) send_px(1, 8'(8'h31 + i));
        idle(4);
        chk_word("t5_w0", 0, 0, 32'h04030201, 4'hF, 1'b0);
        chk_word("t5_w1", 0, 1, 32'h08070605, 4'hF, 1'b1);
        chk("t5_words", 64'(log_q[0].size()), 64'd2);
        chk_word("t5_fp10_w0", 1, 0, 32'h34333231, 4'hF, 1'b0);

        // Random valid/ready over 1000 pixels, fp10, fresh frame after reset
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        clear_stats();
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 1) == 0) idle(1);
                    send_px(1, 8'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rdy[1] = ($urandom_range(0, 9) < 3);
                    @(posedge clk);
                    #1;
                end
            end
        join
        rdy[1] = 1'b1;
        idle(6);
        chk("rnd_fcnt", 64'(ofcnt[1]), 64'd100);
        chk("rnd_words", 64'(log_q[1].size()), 64'd300);
        chk("rnd_done_pulses", 64'(done_cnt[1]), 64'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
